// File: rtl/ex_stage_pkg.sv
// Shared encodings for the execute stage: ALU operation codes and the
// instruction-class codes produced by the main decoder.
package ex_stage_pkg;

   typedef enum logic [3:0] {
      OP_AND  = 4'b0000,
      OP_OR   = 4'b0001,
      OP_ADD  = 4'b0010,
      OP_XOR  = 4'b0011,
      OP_SLL  = 4'b0100,
      OP_SRL  = 4'b0101,
      OP_SUB  = 4'b0110,
      OP_SRA  = 4'b0111,
      OP_SLT  = 4'b1000,
      OP_SLTU = 4'b1001
   } alu_ctrl_e;

   localparam logic [1:0] CLASS_MEM    = 2'b00;
   localparam logic [1:0] CLASS_BRANCH = 2'b01;
   localparam logic [1:0] CLASS_RTYPE  = 2'b10;
   localparam logic [1:0] CLASS_ITYPE  = 2'b11;

endpackage

// File: rtl/ex_stage_alu_core.sv
// Combinational ALU: executes one of the encoded operations on a and b.
// Unused operation codes produce a zero result.
module alu_core
   import ex_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [3:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   logic [4:0] shamt;

   assign shamt = b[4:0];

   always_comb begin
      result = '0;
      case (op)
         OP_AND:  result = a & b;
         OP_OR:   result = a | b;
         OP_ADD:  result = a + b;
         OP_XOR:  result = a ^ b;
         OP_SLL:  result = a << shamt;
         OP_SRL:  result = a >> shamt;
         OP_SUB:  result = a - b;
         OP_SRA:  result = $signed(a) >>> shamt;
         OP_SLT:  result[0] = $signed(a) < $signed(b);
         OP_SLTU: result[0] = a < b;
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU control decode, operand-B select, branch target adder
// and the EX/MEM pipeline register feeding the branch decision.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      alu_op,
   input  logic [3:0]      funct73,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] imm,
   input  logic            alu_src,
   input  logic [XLEN-1:0] pc,
   input  logic            branch,
   output logic [XLEN-1:0] alu_result,
   output logic            zero,
   output logic [XLEN-1:0] branch_target,
   output logic [XLEN-1:0] alu_result_q,
   output logic [XLEN-1:0] branch_target_q,
   output logic [XLEN-1:0] store_data_q,
   output logic            zero_q,
   output logic            branch_q,
   output logic            take_branch
);

   alu_ctrl_e       op;
   logic [XLEN-1:0] operand_b;

   // I-type funct3=000 is ADDI; instr[30] there is immediate data, not a SUB select.
   always_comb begin
      op = OP_ADD;
      case (alu_op)
         CLASS_MEM:    op = OP_ADD;
         CLASS_BRANCH: op = OP_SUB;
         default: begin
            case (funct73[2:0])
               3'b000:  op = (alu_op == CLASS_RTYPE && funct73[3]) ? OP_SUB : OP_ADD;
               3'b001:  op = OP_SLL;
               3'b010:  op = OP_SLT;
               3'b011:  op = OP_SLTU;
               3'b100:  op = OP_XOR;
               3'b101:  op = funct73[3] ? OP_SRA : OP_SRL;
               3'b110:  op = OP_OR;
               default: op = OP_AND;
            endcase
         end
      endcase
   end

   assign operand_b     = alu_src ? imm : rs2_data;
   assign branch_target = pc + imm;

   alu_core #(
      .XLEN(XLEN)
   ) u_alu (
      .op    (op),
      .a     (rs1_data),
      .b     (operand_b),
      .result(alu_result),
      .zero  (zero)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_result_q    <= '0;
         branch_target_q <= '0;
         store_data_q    <= '0;
         zero_q          <= 1'b0;
         branch_q        <= 1'b0;
      end else begin
         alu_result_q    <= alu_result;
         branch_target_q <= branch_target;
         store_data_q    <= rs2_data;
         zero_q          <= zero;
         branch_q        <= branch;
      end
   end

   assign take_branch = branch_q & zero_q;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: a vector table drives the stage, expected
// registered results travel through a scoreboard queue until the next edge.
module tb_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  alu_op;
   logic [3:0]  funct73;
   logic [31:0] rs1_data, rs2_data, imm, pc;
   logic        alu_src, branch;
   logic [31:0] alu_result, branch_target;
   logic [31:0] alu_result_q, branch_target_q, store_data_q;
   logic        zero, zero_q, branch_q, take_branch;

   typedef struct {
      logic [1:0]  alu_op;
      logic [3:0]  funct73;
      logic [31:0] rs1;
      logic [31:0] rs2;
      logic [31:0] imm;
      logic        alu_src;
      logic [31:0] pc;
      logic        branch;
      logic [31:0] res;
      logic        zero;
      logic [31:0] target;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [31:0] target;
      logic [31:0] store;
      logic        zero;
      logic        branch;
      logic        take;
   } exp_t;

   localparam int NVEC = 17;
   vec_t vecs[NVEC];
   exp_t sb[$];
   int   checks = 0;
   int   fails  = 0;

   always #5 clk = ~clk;

   ex_stage #(.XLEN(32)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alu_op         (alu_op),
      .funct73        (funct73),
      .rs1_data       (rs1_data),
      .rs2_data       (rs2_data),
      .imm            (imm),
      .alu_src        (alu_src),
      .pc             (pc),
      .branch         (branch),
      .alu_result     (alu_result),
      .zero           (zero),
      .branch_target  (branch_target),
      .alu_result_q   (alu_result_q),
      .branch_target_q(branch_target_q),
      .store_data_q   (store_data_q),
      .zero_q         (zero_q),
      .branch_q       (branch_q),
      .take_branch    (take_branch)
   );

   task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic driveInputs(input vec_t v);
      alu_op   = v.alu_op;
      funct73  = v.funct73;
      rs1_data = v.rs1;
      rs2_data = v.rs2;
      imm      = v.imm;
      alu_src  = v.alu_src;
      pc       = v.pc;
      branch   = v.branch;
   endtask

   task automatic checkRegsCleared(input string tag);
      checkValue({tag, " alu_result_q"}, alu_result_q, 32'h0);
      checkValue({tag, " branch_target_q"}, branch_target_q, 32'h0);
      checkValue({tag, " store_data_q"}, store_data_q, 32'h0);
      checkValue({tag, " zero_q"}, 32'(zero_q), 32'h0);
      checkValue({tag, " branch_q"}, 32'(branch_q), 32'h0);
      checkValue({tag, " take_branch"}, 32'(take_branch), 32'h0);
   endtask

   // Drive on the falling edge, check the combinational outputs, queue the registered expectation.
   task automatic applyStimulus(input int idx);
      exp_t e;
      vec_t v;
      v = vecs[idx];
      @(negedge clk);
      driveInputs(v);
      e.res    = v.res;
      e.target = v.target;
      e.store  = v.rs2;
      e.zero   = v.zero;
      e.branch = v.branch;
      e.take   = v.branch & v.zero;
      sb.push_back(e);
      #1;
      checkValue($sformatf("v%0d alu_result", idx), alu_result, v.res);
      checkValue($sformatf("v%0d zero", idx), 32'(zero), 32'(v.zero));
      checkValue($sformatf("v%0d branch_target", idx), branch_target, v.target);
   endtask

   task automatic checkOutput(input int idx);
      exp_t e;
      @(posedge clk);
      #1;
      checks++;
      if (sb.size() == 0) begin
         fails++;
         $display("[TB] FAIL v%0d scoreboard: got empty queue expected one entry", idx);
      end else begin
         checks--;
         e = sb.pop_front();
         checkValue($sformatf("v%0d alu_result_q", idx), alu_result_q, e.res);
         checkValue($sformatf("v%0d branch_target_q", idx), branch_target_q, e.target);
         checkValue($sformatf("v%0d store_data_q", idx), store_data_q, e.store);
         checkValue($sformatf("v%0d zero_q", idx), 32'(zero_q), 32'(e.zero));
         checkValue($sformatf("v%0d branch_q", idx), 32'(branch_q), 32'(e.branch));
         checkValue($sformatf("v%0d take_branch", idx), 32'(take_branch), 32'(e.take));
      end
   endtask

   initial begin
      //             op     f73      rs1           rs2           imm           src   pc            br    result        z     target
      vecs[0]  = '{2'b10, 4'b1000, 32'h00000005, 32'h00000005, 32'h00000000, 1'b0, 32'h00001000, 1'b1, 32'h00000000, 1'b1, 32'h00001000};
      vecs[1]  = '{2'b11, 4'b1000, 32'h7FFFFFFF, 32'h00000000, 32'h00000001, 1'b1, 32'h00001000, 1'b0, 32'h80000000, 1'b0, 32'h00001001};
      vecs[2]  = '{2'b10, 4'b1101, 32'h80000000, 32'h00000004, 32'h00000000, 1'b0, 32'h00001000, 1'b0, 32'hF8000000, 1'b0, 32'h00001000};
      vecs[3]  = '{2'b10, 4'b0101, 32'h80000000, 32'h00000004, 32'h00000000, 1'b0, 32'h00001000, 1'b0, 32'h08000000, 1'b0, 32'h00001000};
      vecs[4]  = '{2'b10, 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h00001000, 1'b0, 32'h00000001, 1'b0, 32'h00001000};
      vecs[5]  = '{2'b10, 4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h00001000, 1'b0, 32'h00000000, 1'b1, 32'h00001000};
      vecs[6]  = '{2'b00, 4'b0010, 32'h00000010, 32'hCAFEF00D, 32'hFFFFFFF8, 1'b1, 32'h00000100, 1'b0, 32'h00000008, 1'b0, 32'h000000F8};
      vecs[7]  = '{2'b01, 4'b0000, 32'h00000003, 32'h00000003, 32'h00000020, 1'b0, 32'h00001000, 1'b1, 32'h00000000, 1'b1, 32'h00001020};
      vecs[8]  = '{2'b01, 4'b0001, 32'h00000003, 32'h00000004, 32'hFFFFFFFC, 1'b0, 32'h00001000, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h00000FFC};
      vecs[9]  = '{2'b10, 4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00000000, 1'b0, 32'h00001000, 1'b0, 32'h0FF00FF0, 1'b0, 32'h00001000};
      vecs[10] = '{2'b10, 4'b0110, 32'h0F00000F, 32'h00F000F0, 32'h00000000, 1'b0, 32'h00001000, 1'b0, 32'h0FF000FF, 1'b0, 32'h00001000};
      vecs[11] = '{2'b10, 4'b0111, 32'hFFFF0000, 32'h0F0F0F0F, 32'h00000000, 1'b0, 32'h00001000, 1'b0, 32'h0F0F0000, 1'b0, 32'h00001000};
      vecs[12] = '{2'b10, 4'b0001, 32'h00000001, 32'h00000025, 32'h00000000, 1'b0, 32'h00001000, 1'b0, 32'h00000020, 1'b0, 32'h00001000};
      vecs[13] = '{2'b11, 4'b0001, 32'h00000003, 32'h00000009, 32'h00000004, 1'b1, 32'h00001000, 1'b0, 32'h00000030, 1'b0, 32'h00001004};
      vecs[14] = '{2'b10, 4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 32'h00001000, 1'b1, 32'h00000000, 1'b1, 32'h00001000};
      vecs[15] = '{2'b11, 4'b1101, 32'h80000000, 32'h00000000, 32'h00000401, 1'b1, 32'h00001000, 1'b0, 32'hC0000000, 1'b0, 32'h00001401};
      vecs[16] = '{2'b10, 4'b1000, 32'h00000000, 32'h00000001, 32'h00000000, 1'b0, 32'h00001000, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h00001000};

      // Reset held across a clock edge: registers stay clear, combinational path stays live.
      rst_n = 1'b0;
      driveInputs(vecs[1]);
      #12;
      checkRegsCleared("reset");
      checkValue("reset alu_result", alu_result, 32'h80000000);
      checkValue("reset branch_target", branch_target, 32'h00001001);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         applyStimulus(i);
         checkOutput(i);
      end

      // Mid-cycle reset clears registers without waiting for a clock edge.
      applyStimulus(6);
      checkOutput(6);
      #2;
      rst_n = 1'b0;
      #1;
      checkRegsCleared("async reset");
      @(negedge clk);
      rst_n = 1'b1;
      sb.delete();

      // First edge after reset release captures normally.
      applyStimulus(0);
      checkOutput(0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
